// File: rtl/uart_param_if.sv
// ---------------------------------------------------------------------------
// uart_param_if -- signal bundle between a UART user and uart_param.
//
// Signals (direction seen from the UART, i.e. the slave modport):
//   bitxce   in   oversample enable, OS pulses per bit period
//   load     in   transmit request, honoured only while txbusy is low
//   d        in   DATABITS-wide word to transmit
//   rxpin    in   asynchronous serial input, idle high
//   txpin    out  serial output, idle high
//   txbusy   out  transmitter busy
//   bytercvd out  one-clk pulse when a received frame completes
//   q        out  last received data word
//   framerr  out  stop bit of last frame sampled low
//   parerr   out  parity mismatch in last frame
// ---------------------------------------------------------------------------
interface uart_param_if #(
  parameter int DATABITS = 8
);
  logic                bitxce;
  logic                load;
  logic [DATABITS-1:0] d;
  logic                rxpin;
  logic                txpin;
  logic                txbusy;
  logic                bytercvd;
  logic [DATABITS-1:0] q;
  logic                framerr;
  logic                parerr;

  modport master (
    output bitxce, load, d, rxpin,
    input  txpin, txbusy, bytercvd, q, framerr, parerr
  );

  modport slave (
    input  bitxce, load, d, rxpin,
    output txpin, txbusy, bytercvd, q, framerr, parerr
  );
endinterface

// File: rtl/uart_param.sv
// ---------------------------------------------------------------------------
// uart_param -- full-duplex UART with compile-time frame format.
//
// Parameters:
//   DATABITS  data bits per frame (5..8)
//   PARITY    0 none, 1 odd, 2 even
//   STOPBITS  transmitted stop bits (1 or 2)
//   SUBDIV16  oversampling ratio: 0 -> 8, 1 -> 16 bitxce pulses per bit
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  uart_param_if.slave (bitxce/load/d/rxpin in,
//        txpin/txbusy/bytercvd/q/framerr/parerr out)
//
// The transmitter shifts a prebuilt frame out one bit per OS bitxce pulses.
// The receiver synchronises rxpin, detects the start edge, re-checks it half
// a bit later and then samples every OS pulses near the bit centre.
// ---------------------------------------------------------------------------
module uart_param #(
  parameter int DATABITS = 8,
  parameter int PARITY   = 0,
  parameter int STOPBITS = 1,
  parameter int SUBDIV16 = 0
) (
  input  logic         clk,
  input  logic         rst,
  uart_param_if.slave  bus
);

  localparam int         OS      = (SUBDIV16 != 0) ? 16 : 8;
  localparam int         PAR_W   = (PARITY != 0) ? 1 : 0;
  localparam int         FRAME_W = 1 + DATABITS + PAR_W + STOPBITS;
  localparam logic [3:0] OS_LAST = 4'(OS - 1);
  localparam logic [3:0] OS_HALF = 4'(OS / 2 - 1);
  localparam logic [3:0] TX_LEFT = 4'(FRAME_W - 1);
  localparam logic [2:0] RX_LAST = 3'(DATABITS - 1);

  // Parity bit for a data word: XOR for even, inverted XOR for odd.
  function automatic logic par_bit(input logic [DATABITS-1:0] v);
    return (PARITY == 1) ? ~(^v) : (^v);
  endfunction

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  logic                 r_txpin;
  logic                 r_txbusy;
  logic [FRAME_W-2:0]   r_tx_shreg;   // bits still to send after the start bit
  logic [3:0]           r_tx_sub;     // bitxce pulses within current bit
  logic [3:0]           r_tx_left;    // bits remaining after the current one
  logic [FRAME_W-2:0]   w_tx_body;

  // Frame body without the start bit: data LSB first, parity, stop bits.
  always_comb begin
    w_tx_body                 = '1;
    w_tx_body[DATABITS-1:0]   = bus.d;
    if (PARITY != 0) begin
      w_tx_body[DATABITS]     = par_bit(bus.d);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txpin    <= 1'b1;
      r_txbusy   <= 1'b0;
      r_tx_shreg <= '1;
      r_tx_sub   <= '0;
      r_tx_left  <= '0;
    end else if (!r_txbusy) begin
      // Load acceptance is the only action that does not wait for bitxce.
      if (bus.load) begin
        r_txbusy   <= 1'b1;
        r_txpin    <= 1'b0;
        r_tx_shreg <= w_tx_body;
        r_tx_sub   <= '0;
        r_tx_left  <= TX_LEFT;
      end
    end else if (bus.bitxce) begin
      if (r_tx_sub == OS_LAST) begin
        r_tx_sub <= '0;
        if (r_tx_left == '0) begin
          // Last stop bit just ended.
          r_txbusy <= 1'b0;
          r_txpin  <= 1'b1;
        end else begin
          r_txpin    <= r_tx_shreg[0];
          r_tx_shreg <= {1'b1, r_tx_shreg[FRAME_W-2:1]};
          r_tx_left  <= r_tx_left - 4'd1;
        end
      end else begin
        r_tx_sub <= r_tx_sub + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Receiver
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAKWAIT
  } rx_state_t;

  logic [1:0]          r_rx_sync;
  rx_state_t           r_rx_state;
  logic [3:0]          r_rx_sub;
  logic [2:0]          r_rx_cnt;
  logic [DATABITS-1:0] r_rx_shreg;
  logic                r_rx_parbad;
  logic [DATABITS-1:0] r_q;
  logic                r_framerr;
  logic                r_parerr;
  logic                r_bytercvd;

  rx_state_t           w_rx_state;
  logic [3:0]          w_rx_sub;
  logic [2:0]          w_rx_cnt;
  logic [DATABITS-1:0] w_rx_shreg;
  logic                w_rx_parbad;
  logic [DATABITS-1:0] w_q;
  logic                w_framerr;
  logic                w_parerr;
  logic                w_bytercvd;
  logic                w_rx;
  logic                w_bit_end;

  assign w_rx      = r_rx_sync[1];
  assign w_bit_end = (r_rx_sub == OS_LAST);

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rx_state  = r_rx_state;
    w_rx_sub    = r_rx_sub;
    w_rx_cnt    = r_rx_cnt;
    w_rx_shreg  = r_rx_shreg;
    w_rx_parbad = r_rx_parbad;
    w_q         = r_q;
    w_framerr   = r_framerr;
    w_parerr    = r_parerr;
    w_bytercvd  = 1'b0;

    if (bus.bitxce) begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!w_rx) begin
            w_rx_state = RX_START;
            w_rx_sub   = '0;
          end
        end
        RX_START: begin
          // Re-check at mid start bit; a high line here was a glitch.
          if (r_rx_sub == OS_HALF) begin
            w_rx_sub   = '0;
            w_rx_cnt   = '0;
            w_rx_state = w_rx ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_sub = r_rx_sub + 4'd1;
          end
        end
        RX_DATA: begin
          if (w_bit_end) begin
            w_rx_sub   = '0;
            w_rx_shreg = {w_rx, r_rx_shreg[DATABITS-1:1]};
            w_rx_cnt   = r_rx_cnt + 3'd1;
            if (r_rx_cnt == RX_LAST) begin
              w_rx_state = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end
          end else begin
            w_rx_sub = r_rx_sub + 4'd1;
          end
        end
        RX_PARITY: begin
          if (w_bit_end) begin
            w_rx_sub    = '0;
            w_rx_parbad = (w_rx != par_bit(r_rx_shreg));
            w_rx_state  = RX_STOP;
          end else begin
            w_rx_sub = r_rx_sub + 4'd1;
          end
        end
        RX_STOP: begin
          // Only the first stop bit is checked; a second one looks like idle.
          if (w_bit_end) begin
            w_rx_sub   = '0;
            w_q        = r_rx_shreg;
            w_framerr  = !w_rx;
            w_parerr   = (PARITY != 0) && r_rx_parbad;
            w_bytercvd = 1'b1;
            w_rx_state = w_rx ? RX_IDLE : RX_BREAKWAIT;
          end else begin
            w_rx_sub = r_rx_sub + 4'd1;
          end
        end
        RX_BREAKWAIT: begin
          // A held-low line must go high before another start is accepted.
          if (w_rx) begin
            w_rx_state = RX_IDLE;
          end
        end
        default: w_rx_state = RX_IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous and covers every register, including the
  // data shift register, so q reads 0 after reset and no X reaches outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync   <= 2'b11;
      r_rx_state  <= RX_IDLE;
      r_rx_sub    <= '0;
      r_rx_cnt    <= '0;
      r_rx_shreg  <= '0;
      r_rx_parbad <= 1'b0;
      r_q         <= '0;
      r_framerr   <= 1'b0;
      r_parerr    <= 1'b0;
      r_bytercvd  <= 1'b0;
    end else begin
      r_rx_sync   <= {r_rx_sync[0], bus.rxpin};
      r_rx_state  <= w_rx_state;
      r_rx_sub    <= w_rx_sub;
      r_rx_cnt    <= w_rx_cnt;
      r_rx_shreg  <= w_rx_shreg;
      r_rx_parbad <= w_rx_parbad;
      r_q         <= w_q;
      r_framerr   <= w_framerr;
      r_parerr    <= w_parerr;
      r_bytercvd  <= w_bytercvd;
    end
  end

  assign bus.txpin    = r_txpin;
  assign bus.txbusy   = r_txbusy;
  assign bus.bytercvd = r_bytercvd;
  assign bus.q        = r_q;
  assign bus.framerr  = r_framerr;
  assign bus.parerr   = r_parerr;

endmodule

// File: tb/tb_uart_param.sv
// ---------------------------------------------------------------------------
// tb_uart_param -- self-checking bench for uart_param.
//
// Three instances share one clock and a bitxce pulse every 4 clk:
//   A: defaults (8N1, OS=8)          -- tx waveform, rx, glitch, break, reset
//   B: 7 bits, even parity, OS=8     -- txpin looped back to rxpin
//   C: 8 bits, odd parity, 2 stop, OS=16 -- rx with injected parity errors
// Received frames are checked against a queue of expected results filled
// when each frame is driven.
// ---------------------------------------------------------------------------
module tb_uart_param;

  typedef struct packed {
    logic [7:0] q;
    logic       fe;
    logic       pe;
  } rx_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_bc;
  logic bitxce;
  int   bx_cnt;
  logic a_rx;
  logic c_rx;

  int n_checks = 0;
  int n_fail   = 0;
  int a_rcv_cnt = 0;

  rx_exp_t qa[$];
  rx_exp_t qb[$];
  rx_exp_t qc[$];

  uart_param_if #(.DATABITS(8)) if_a ();
  uart_param_if #(.DATABITS(7)) if_b ();
  uart_param_if #(.DATABITS(8)) if_c ();

  assign if_a.bitxce = bitxce;
  assign if_b.bitxce = bitxce;
  assign if_c.bitxce = bitxce;
  assign if_a.rxpin  = a_rx;
  assign if_b.rxpin  = if_b.txpin;
  assign if_c.rxpin  = c_rx;

  uart_param #(.DATABITS(8), .PARITY(0), .STOPBITS(1), .SUBDIV16(0)) dut_a (
    .clk (clk), .rst (rst_a), .bus (if_a.slave)
  );
  uart_param #(.DATABITS(7), .PARITY(2), .STOPBITS(1), .SUBDIV16(0)) dut_b (
    .clk (clk), .rst (rst_bc), .bus (if_b.slave)
  );
  uart_param #(.DATABITS(8), .PARITY(1), .STOPBITS(2), .SUBDIV16(1)) dut_c (
    .clk (clk), .rst (rst_bc), .bus (if_c.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // bitxce high for one clk out of every four.
  initial begin
    bx_cnt = 0;
    bitxce = 1'b0;
    forever begin
      @(negedge clk);
      bx_cnt = (bx_cnt + 1) % 4;
      bitxce = (bx_cnt == 0);
    end
  end

  // Receive-side scoreboards.
  always @(negedge clk) begin : mon_a
    rx_exp_t e;
    if (if_a.bytercvd === 1'b1) begin
      a_rcv_cnt++;
      if (qa.size() == 0) check("a_rx_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_rx_q", if_a.q, e.q);
        check("a_rx_framerr", if_a.framerr, e.fe);
        check("a_rx_parerr", if_a.parerr, e.pe);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    rx_exp_t e;
    if (if_b.bytercvd === 1'b1) begin
      if (qb.size() == 0) check("b_rx_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_rx_q", if_b.q, e.q);
        check("b_rx_framerr", if_b.framerr, e.fe);
        check("b_rx_parerr", if_b.parerr, e.pe);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    rx_exp_t e;
    if (if_c.bytercvd === 1'b1) begin
      if (qc.size() == 0) check("c_rx_unexpected", 1, 0);
      else begin
        e = qc.pop_front();
        check("c_rx_q", if_c.q, e.q);
        check("c_rx_framerr", if_c.framerr, e.fe);
        check("c_rx_parerr", if_c.parerr, e.pe);
      end
    end
  end

  task automatic push_exp(input int inst, input logic [7:0] v, input logic fe, input logic pe);
    rx_exp_t e;
    e.q  = v;
    e.fe = fe;
    e.pe = pe;
    case (inst)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  // Present load in the same cycle as a bitxce pulse; returns one negedge
  // after the accepting edge.
  task automatic do_load(input int inst, input logic [7:0] v);
    do @(posedge clk); while (bx_cnt != 3);
    @(negedge clk);
    if (inst == 0) begin if_a.d = v;      if_a.load = 1'b1; end
    else           begin if_b.d = v[6:0]; if_b.load = 1'b1; end
    @(negedge clk);
    if_a.load = 1'b0;
    if_b.load = 1'b0;
  endtask

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) a_rx = v;
    else           c_rx = v;
  endtask

  // Drive one serial frame onto rxpin of instance A (0) or C (2).
  task automatic send_serial(input int inst, input logic [7:0] v, input int nbits,
                             input int par, input bit flip, input int nstop, input int bclk);
    logic [15:0] fr;
    logic        x;
    int          n;
    fr    = '1;
    fr[0] = 1'b0;
    x     = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      fr[1+i] = v[i];
      x       = x ^ v[i];
    end
    n = 1 + nbits;
    if (par != 0) begin
      fr[n] = ((par == 1) ? ~x : x) ^ flip;
      n++;
    end
    n += nstop;
    for (int b = 0; b < n; b++) begin
      set_rx(inst, fr[b]);
      repeat (bclk) @(negedge clk);
    end
    set_rx(inst, 1'b1);
  endtask

  initial begin
    logic [9:0]  exp_frame;
    logic [6:0]  b_vals [4];
    int          k;
    int          busy_cnt;
    int          cnt0;

    rst_a  = 1'b1;
    rst_bc = 1'b1;
    a_rx   = 1'b1;
    c_rx   = 1'b1;
    if_a.load = 1'b0; if_a.d = '0;
    if_b.load = 1'b0; if_b.d = '0;
    if_c.load = 1'b0; if_c.d = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("a_rst_txpin",    if_a.txpin,    1);
    check("a_rst_txbusy",   if_a.txbusy,   0);
    check("a_rst_bytercvd", if_a.bytercvd, 0);
    check("a_rst_q",        if_a.q,        0);
    check("a_rst_framerr",  if_a.framerr,  0);
    check("a_rst_parerr",   if_a.parerr,   0);
    check("b_rst_txpin",    if_b.txpin,    1);
    check("c_rst_parerr",   if_c.parerr,   0);
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    repeat (8) @(negedge clk);

    // A: transmit 0xA5, a stray load mid-frame, and a load in the final cycle
    exp_frame = {1'b1, 8'hA5, 1'b0};
    do_load(0, 8'hA5);
    k        = 0;
    busy_cnt = 0;
    while (if_a.txbusy && k < 400) begin
      busy_cnt++;
      if (k % 32 == 16) check($sformatf("a_tx_bit%0d", k / 32), if_a.txpin, exp_frame[k/32]);
      if (k == 100) begin if_a.d = 8'hFF; if_a.load = 1'b1; end
      if (k == 101) if_a.load = 1'b0;
      if (k == 319) begin if_a.d = 8'h00; if_a.load = 1'b1; end
      @(negedge clk);
      k++;
    end
    if_a.load = 1'b0;
    check("a_tx_busy_len",  busy_cnt,    320);
    check("a_tx_late_load", if_a.txbusy, 0);
    check("a_tx_idle_pin",  if_a.txpin,  1);
    repeat (40) @(negedge clk);
    check("a_tx_still_idle", if_a.txbusy, 0);

    // A: plain receive
    push_exp(0, 8'hC3, 1'b0, 1'b0);
    send_serial(0, 8'hC3, 8, 0, 1'b0, 1, 32);
    repeat (40) @(negedge clk);
    check("a_rx_drain1", qa.size(), 0);

    // A: short low glitch must not start a frame
    cnt0 = a_rcv_cnt;
    a_rx = 1'b0;
    repeat (8) @(negedge clk);
    a_rx = 1'b1;
    repeat (400) @(negedge clk);
    check("a_glitch_nobyte", a_rcv_cnt - cnt0, 0);
    push_exp(0, 8'h96, 1'b0, 1'b0);
    send_serial(0, 8'h96, 8, 0, 1'b0, 1, 32);
    repeat (40) @(negedge clk);
    check("a_rx_drain2", qa.size(), 0);

    // A: line held low for 20 bit periods (break)
    cnt0 = a_rcv_cnt;
    push_exp(0, 8'h00, 1'b1, 1'b0);
    a_rx = 1'b0;
    repeat (640) @(negedge clk);
    check("a_break_once",  a_rcv_cnt - cnt0, 1);
    check("a_break_drain", qa.size(), 0);
    check("a_break_hold_fe", if_a.framerr, 1);
    a_rx = 1'b1;
    repeat (64) @(negedge clk);
    push_exp(0, 8'h3C, 1'b0, 1'b0);
    send_serial(0, 8'h3C, 8, 0, 1'b0, 1, 32);
    repeat (40) @(negedge clk);
    check("a_after_break_cnt", a_rcv_cnt - cnt0, 2);
    repeat (200) @(negedge clk);
    check("a_q_hold", if_a.q, 8'h3C);

    // A: reset during tx frame and rx DATA
    cnt0 = a_rcv_cnt;
    do_load(0, 8'h00);
    a_rx = 1'b0;
    repeat (32) @(negedge clk);
    a_rx = 1'b1;
    repeat (64) @(negedge clk);
    check("a_pre_rst_busy",  if_a.txbusy, 1);
    check("a_pre_rst_txpin", if_a.txpin,  0);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_rst_mid_txpin",  if_a.txpin,  1);
    check("a_rst_mid_txbusy", if_a.txbusy, 0);
    check("a_rst_mid_q",      if_a.q,      0);
    rst_a = 1'b0;
    repeat (500) @(negedge clk);
    check("a_rst_no_byte",   a_rcv_cnt - cnt0, 0);
    check("a_rst_idle_busy", if_a.txbusy, 0);

    // B: loopback, 7 data bits with even parity
    b_vals = '{7'h55, 7'h00, 7'h7F, 7'h2A};
    foreach (b_vals[i]) begin
      push_exp(1, {1'b0, b_vals[i]}, 1'b0, 1'b0);
      do_load(1, {1'b0, b_vals[i]});
      k = 0;
      while (if_b.txbusy && k < 600) begin
        @(negedge clk);
        k++;
      end
      check("b_tx_done", if_b.txbusy, 0);
      repeat (20) @(negedge clk);
    end
    check("b_rx_drain", qb.size(), 0);

    // C: odd parity, OS=16, injected parity error then recovery
    push_exp(2, 8'h5A, 1'b0, 1'b0);
    send_serial(2, 8'h5A, 8, 1, 1'b0, 2, 64);
    repeat (80) @(negedge clk);
    push_exp(2, 8'h81, 1'b0, 1'b1);
    send_serial(2, 8'h81, 8, 1, 1'b1, 2, 64);
    repeat (80) @(negedge clk);
    check("c_parerr_held", if_c.parerr, 1);
    push_exp(2, 8'h7E, 1'b0, 1'b0);
    send_serial(2, 8'h7E, 8, 1, 1'b0, 2, 64);
    repeat (80) @(negedge clk);
    check("c_parerr_cleared", if_c.parerr, 0);
    check("c_rx_drain", qc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 SHALL have parameter DATABITS, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 odd, 2 even).
REQ-003 SHALL have parameter STOPBITS, default 1, transmitted stop bits (legal 1, 2).
REQ-004 SHALL have parameter SUBDIV16, default 0, oversampling ratio OS (0: OS=8, 1: OS=16).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port bitxce  input  1  oversample enable, high OS times per bit period, one clk each.
REQ-008 SHALL have port load  input  1  transmit request; accepted only when txbusy low.
REQ-009 SHALL have port d  input  DATABITS  byte to transmit.
REQ-010 SHALL have port rxpin  input  1  asynchronous serial input, idle high.
REQ-011 SHALL have port txpin  output  1  serial output, true polarity, idle high.
REQ-012 SHALL have port txbusy  output  1  transmitter busy; load ignored while high.
REQ-013 SHALL have port bytercvd  output  1  one-clk pulse, received frame complete.
REQ-014 SHALL have port q  output  DATABITS  last received data word.
REQ-015 SHALL have port framerr  output  1  stop bit of last frame sampled low.
REQ-016 SHALL have port parerr  output  1  parity mismatch in last frame (always 0 when PARITY=0).

Function
REQ-017 Transmit: load with txbusy low SHALL latch d and raise txbusy and drive txpin low (start bit) on the next clk edge.
REQ-018 Each tx bit SHALL last exactly OS bitxce pulses, counted by a tx sub-bit counter cleared on accepted load.
REQ-019 Tx frame order SHALL be start(0), d LSB first, parity bit if PARITY!=0, STOPBITS stop bits(1).
REQ-020 Parity bit SHALL be XOR of data bits (even) or its inverse (odd).
REQ-021 txbusy SHALL fall on the clk edge ending the last stop bit; load in that same cycle is not accepted (txbusy still high).
REQ-022 load while txbusy high SHALL have no effect on the frame in progress.
REQ-023 rxpin SHALL pass a 2-flop synchroniser; all rx decisions use the synchronised value.
REQ-024 Rx FSM states: IDLE, START, DATA, PARITY, STOP, BREAKWAIT.
REQ-025 IDLE->START on synchronised rxpin low at a bitxce; rx sub-bit counter cleared.
REQ-026 START: after OS/2 bitxce pulses sample; high -> IDLE (false start, no bytercvd), low -> DATA.
REQ-027 DATA: sample every OS bitxce pulses, shift LSB first, DATABITS samples, then PARITY (if enabled) else STOP.
REQ-028 PARITY: one sample OS pulses later, compare against computed parity.
REQ-029 STOP: one sample OS pulses later; only the first stop bit checked regardless of STOPBITS.
REQ-030 At the stop sample cycle: q, framerr, parerr SHALL update and bytercvd pulse high for exactly that clk.
REQ-031 Stop sampled high -> IDLE; low -> BREAKWAIT, which returns to IDLE only after synchronised rxpin high.
REQ-032 q, framerr, parerr SHALL hold until the next bytercvd.
REQ-033 Tx and rx SHALL operate fully independently and concurrently (full duplex).
REQ-034 bitxce low SHALL freeze both sub-bit counters; no state advances without bitxce except load acceptance.

Reset
REQ-035 rst high SHALL, at next clk edge, force txpin=1, txbusy=0, bytercvd=0, q=0, framerr=0, parerr=0, rx FSM IDLE, counters 0, synchroniser 1s.
REQ-036 rst SHALL take priority over load and bitxce; a frame in progress is abandoned, txpin returns high immediately.

Verification
REQ-037 Defaults, bitxce every 4 clk, load d=8'hA5 -> txpin 0,1,0,1,0,0,1,0,1,1 each 32 clk; txbusy high 320 clk.
REQ-038 Loopback txpin->rxpin, PARITY=2, DATABITS=7, d=7'h55 -> one bytercvd, q=7'h55, parerr=0, framerr=0.
REQ-039 Rx low glitch 2 bitxce long then high -> no bytercvd, FSM back to IDLE.
REQ-040 Rx held low 20 bit periods -> bytercvd once, q=0, framerr=1; no further bytercvd until rxpin high then new frame.
REQ-041 PARITY=1, injected wrong parity bit -> parerr=1 at bytercvd; next good frame clears parerr.
REQ-042 rst asserted mid-tx frame and mid-rx DATA -> txpin=1, txbusy=0 next edge; no bytercvd from aborted frame.
